// File: rtl/multi_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_pulse_timer
// Purpose  : Shared-prescaler, multi-channel periodic/one-shot pulse timer.
//            Define PULSE_TIMER_COUNT_OUT_EN to add the live count_o port.
// Revision : 1.0  initial release
// ============================================================================
module multi_pulse_timer #(
  parameter int CLK_DIV  = 50000,
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          start,
  input  logic [NUM_CH-1:0]          stop,
  input  logic [NUM_CH-1:0]          oneshot,
  input  logic [NUM_CH*PERIOD_W-1:0] period,
  output logic                       tick,
  output logic [NUM_CH-1:0]          pulse,
  output logic [NUM_CH-1:0]          running
`ifdef PULSE_TIMER_COUNT_OUT_EN
  ,
  output logic [NUM_CH*PERIOD_W-1:0] count_o
`endif
);

  localparam int                    C_PRESC_W    = $clog2(CLK_DIV);
  localparam logic [C_PRESC_W-1:0]  C_PRESC_LAST = C_PRESC_W'(CLK_DIV - 1);
  localparam logic [C_PRESC_W-1:0]  C_PRESC_ONE  = C_PRESC_W'(1);
  localparam logic [PERIOD_W-1:0]   C_CNT_ONE    = PERIOD_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [C_PRESC_W-1:0] presc_q;
  logic                 tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (presc_q == C_PRESC_LAST) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + C_PRESC_ONE;
      end
      tick_q <= (presc_q == C_PRESC_LAST);
    end
  end

  assign tick = tick_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t              state_q;
    logic [PERIOD_W-1:0] count_q;
    logic [PERIOD_W-1:0] per_lat_q;
    logic                os_lat_q;
    logic                pulse_q;
    logic [PERIOD_W-1:0] w_period;

    assign w_period = period[gi*PERIOD_W +: PERIOD_W];

    // Priority: stop, then (re)start, then tick-driven counting.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_IDLE;
        count_q   <= '0;
        per_lat_q <= '0;
        os_lat_q  <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (stop[gi]) begin
          state_q <= ST_IDLE;
          count_q <= '0;
        end else if (start[gi] && (w_period != '0)) begin
          per_lat_q <= w_period;
          os_lat_q  <= oneshot[gi];
          count_q   <= '0;
          state_q   <= ST_RUN;
        end else if ((state_q == ST_RUN) && tick_q) begin
          if (count_q == (per_lat_q - C_CNT_ONE)) begin
            pulse_q <= 1'b1;
            count_q <= '0;
            if (os_lat_q) begin
              state_q <= ST_IDLE;
            end
          end else begin
            count_q <= count_q + C_CNT_ONE;
          end
        end
      end
    end

    assign pulse[gi]   = pulse_q;
    assign running[gi] = (state_q == ST_RUN);

`ifdef PULSE_TIMER_COUNT_OUT_EN
    assign count_o[gi*PERIOD_W +: PERIOD_W] = count_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_pulse_timer
// Purpose  : Self-checking bench for multi_pulse_timer (CLK_DIV=4, 2 ch, 4-bit).
// Revision : 1.0  initial release
// ============================================================================
module tb_multi_pulse_timer;

  localparam int CLK_DIV = 4;
  localparam int NCH     = 2;
  localparam int PW      = 4;

  logic              clk     = 1'b0;
  logic              rst_n   = 1'b0;
  logic [NCH-1:0]    start   = '0;
  logic [NCH-1:0]    stop    = '0;
  logic [NCH-1:0]    oneshot = '0;
  logic [NCH*PW-1:0] period  = '0;
  logic              tick;
  logic [NCH-1:0]    pulse;
  logic [NCH-1:0]    running;
`ifdef PULSE_TIMER_COUNT_OUT_EN
  logic [NCH*PW-1:0] count_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  multi_pulse_timer #(
    .CLK_DIV  (CLK_DIV),
    .NUM_CH   (NCH),
    .PERIOD_W (PW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .oneshot (oneshot),
    .period  (period),
    .tick    (tick),
    .pulse   (pulse),
    .running (running)
`ifdef PULSE_TIMER_COUNT_OUT_EN
    ,
    .count_o (count_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: edges since release give the tick; each channel keeps the
  // total ticks seen since its start and expires whenever that is a multiple of P.
  int             m_k;
  logic           m_tick;
  logic [NCH-1:0] m_run;
  logic [NCH-1:0] m_pulse;
  logic [NCH-1:0] m_os;
  int             m_ticks [NCH];
  int             m_per   [NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k     <= 0;
      m_tick  <= 1'b0;
      m_run   <= '0;
      m_pulse <= '0;
      m_os    <= '0;
      for (int i = 0; i < NCH; i++) begin
        m_ticks[i] <= 0;
        m_per[i]   <= 0;
      end
    end else begin
      m_k    <= m_k + 1;
      m_tick <= (((m_k + 1) % CLK_DIV) == 0);
      for (int i = 0; i < NCH; i++) begin
        m_pulse[i] <= 1'b0;
        if (stop[i]) begin
          m_run[i] <= 1'b0;
        end else if (start[i] && (period[i*PW +: PW] != 0)) begin
          m_run[i]   <= 1'b1;
          m_ticks[i] <= 0;
          m_per[i]   <= int'(period[i*PW +: PW]);
          m_os[i]    <= oneshot[i];
        end else if (m_run[i] && m_tick) begin
          m_ticks[i] <= m_ticks[i] + 1;
          if (((m_ticks[i] + 1) % m_per[i]) == 0) begin
            m_pulse[i] <= 1'b1;
            if (m_os[i]) m_run[i] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if ({tick, pulse, running} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_outputs: got %b required 00000", {tick, pulse, running});
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tick !== ((c % CLK_DIV) == 0)) begin
        n_err++;
        $display("FAIL tick_cadence: cycle %0d got %b required %b", c, tick, ((c % CLK_DIV) == 0));
      end
      n_cmp++;
      if ({pulse, running, tick} !== {m_pulse, m_run, m_tick}) begin
        n_err++;
        $display("FAIL reset_model: got %b required %b", {pulse, running, tick}, {m_pulse, m_run, m_tick});
      end
    end
  endtask

  task automatic test_periodic();
    int times[$];
    int in_win;
    period[0*PW +: PW] = 4'd3;
    oneshot[0] = 1'b0;
    start[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n_cmp++;
    if (running[0] !== 1'b1) begin
      n_err++;
      $display("FAIL periodic_running: got %b required 1", running[0]);
    end
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      if (pulse[0] === 1'b1) times.push_back(c);
      n_cmp++;
      if (pulse[1] !== 1'b0) begin
        n_err++;
        $display("FAIL periodic_ch1_silent: got %b required 0", pulse[1]);
      end
      n_cmp++;
      if ({pulse, running, tick} !== {m_pulse, m_run, m_tick}) begin
        n_err++;
        $display("FAIL periodic_model: got %b required %b", {pulse, running, tick}, {m_pulse, m_run, m_tick});
      end
    end
    in_win = 0;
    foreach (times[j]) if (times[j] < times[0] + 60) in_win++;
    n_cmp++;
    if (times.size() == 0 || in_win != 5) begin
      n_err++;
      $display("FAIL periodic_count60: got %0d required 5", in_win);
    end
    for (int j = 1; j < times.size(); j++) begin
      n_cmp++;
      if (times[j] - times[j-1] != 12) begin
        n_err++;
        $display("FAIL periodic_interval: got %0d required 12", times[j] - times[j-1]);
      end
    end
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    n_cmp++;
    if (running[0] !== 1'b0) begin
      n_err++;
      $display("FAIL periodic_stop: got %b required 0", running[0]);
    end
  endtask

  task automatic test_oneshot();
    int   npulse;
    logic prev_run;
    npulse = 0;
    period[1*PW +: PW] = 4'd2;
    oneshot[1] = 1'b1;
    start[1]   = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    prev_run = running[1];
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (pulse[1] === 1'b1) begin
        npulse++;
        n_cmp++;
        if (running[1] !== 1'b0 || prev_run !== 1'b1) begin
          n_err++;
          $display("FAIL oneshot_running_edge: got run %b prev %b required 0 prev 1", running[1], prev_run);
        end
      end
      prev_run = running[1];
      n_cmp++;
      if ({pulse, running, tick} !== {m_pulse, m_run, m_tick}) begin
        n_err++;
        $display("FAIL oneshot_model: got %b required %b", {pulse, running, tick}, {m_pulse, m_run, m_tick});
      end
    end
    n_cmp++;
    if (npulse != 1) begin
      n_err++;
      $display("FAIL oneshot_count: got %0d required 1", npulse);
    end
  endtask

  task automatic test_stop();
    int t;
    period[0*PW +: PW] = 4'd3;
    oneshot[0] = 1'b0;
    start[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    t = 0;
    while (!(tick === 1'b1 && m_run[0] && ((m_ticks[0] + 1) % m_per[0]) == 0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 40) begin
      n_err++;
      $display("FAIL stop_wait_expiry: got timeout after %0d cycles required expiry tick", t);
    end
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
    n_cmp++;
    if ({pulse[0], running[0]} !== 2'b00) begin
      n_err++;
      $display("FAIL stop_at_expiry: got pulse/run %b required 00", {pulse[0], running[0]});
    end
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    n_cmp++;
    if (running[0] !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_together: got %b required 0", running[0]);
    end
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (pulse[0] !== 1'b0 || running[0] !== 1'b0) begin
        n_err++;
        $display("FAIL stop_idle_hold: got pulse/run %b required 00", {pulse[0], running[0]});
      end
    end
  endtask

  task automatic test_zero_and_change();
    int t;
    period[0*PW +: PW] = 4'd0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n_cmp++;
    if (running[0] !== 1'b0) begin
      n_err++;
      $display("FAIL zero_period: got %b required 0", running[0]);
    end
    period[0*PW +: PW] = 4'd3;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (pulse[0] !== 1'b1 && t < 40);
      n_cmp++;
      if (pulse[0] !== 1'b1 || (n > 0 && t != 12)) begin
        n_err++;
        $display("FAIL change_mid_run: interval %0d got %0d required 12", n, t);
      end
      if (n == 0) period[0*PW +: PW] = 4'd7;
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (pulse[0] !== 1'b1 && t < 40);
      n_cmp++;
      if (pulse[0] !== 1'b1 || (n > 0 && t != 28)) begin
        n_err++;
        $display("FAIL restart_period7: interval %0d got %0d required 28", n, t);
      end
    end
    stop[0] = 1'b1;
    @(negedge clk);
    stop[0] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({pulse, running, tick} !== {m_pulse, m_run, m_tick}) begin
        n_err++;
        $display("FAIL random_model: cycle %0d got %b required %b", c, {pulse, running, tick}, {m_pulse, m_run, m_tick});
      end
`ifdef PULSE_TIMER_COUNT_OUT_EN
      for (int i = 0; i < NCH; i++) begin
        int e;
        e = m_run[i] ? (m_ticks[i] % m_per[i]) : 0;
        n_cmp++;
        if (count_o[i*PW +: PW] !== PW'(e)) begin
          n_err++;
          $display("FAIL random_count: ch%0d got %0d required %0d", i, count_o[i*PW +: PW], e);
        end
      end
`endif
      for (int i = 0; i < NCH; i++) begin
        start[i]   = ($urandom_range(0, 15) == 0);
        stop[i]    = ($urandom_range(0, 39) == 0);
        oneshot[i] = $urandom_range(0, 1) == 1;
        period[i*PW +: PW] = PW'($urandom_range(0, 5));
      end
    end
    start = '0;
    stop  = '0;
  endtask

  task automatic test_async_reset();
    period  = {4'd2, 4'd2};
    oneshot = '0;
    start   = 2'b11;
    @(negedge clk);
    start = '0;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (running !== 2'b11) begin
      n_err++;
      $display("FAIL async_pre_running: got %b required 11", running);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tick, pulse, running} !== 5'b0) begin
      n_err++;
      $display("FAIL async_reset_drop: got %b required 00000", {tick, pulse, running});
    end
`ifdef PULSE_TIMER_COUNT_OUT_EN
    n_cmp++;
    if (count_o !== '0) begin
      n_err++;
      $display("FAIL async_reset_count: got %h required 0", count_o);
    end
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      n_cmp++;
      if ({pulse, running, tick} !== {m_pulse, m_run, m_tick}) begin
        n_err++;
        $display("FAIL async_post_model: got %b required %b", {pulse, running, tick}, {m_pulse, m_run, m_tick});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_stop();
    test_zero_and_change();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
